// File: rtl/led_arbiter.sv
// Round-robin owner of the 4-bit LED bank: one requester at a time, each for
// at most DWELL_CYC cycles, showing the pattern it presented at grant time.
module led_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         DWELL_CYC = 8,
    parameter logic [3:0] IDLE_PAT  = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] pat,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic [3:0]         led
);

    localparam int CW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYC - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     own, own_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [3:0]        led_nxt;
    logic              busy_nxt;

    logic              slice_end;
    logic [PW-1:0]     base;
    logic [PW:0]       pick;
    logic              win_vld;
    logic [PW-1:0]     win;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] k);
        if (int'(k) == N_REQ - 1)
            return '0;
        else
            return k + PW'(1);
    endfunction

    // Scans from the highest offset down so the requester closest to base wins.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [PW-1:0]    start);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (r[idx])
                res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    // The pointer advances before arbitration so a slice end hands over in one edge.
    assign slice_end = (state == SHOW) && ((cnt == '0) || !req[own]);
    assign base      = slice_end ? next_idx(own) : ptr;
    assign pick      = rr_pick(req, base);
    assign win_vld   = pick[PW];
    assign win       = pick[PW-1:0];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        own_nxt   = own;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        led_nxt   = led;
        busy_nxt  = busy;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt    = SHOW;
                    own_nxt      = win;
                    cnt_nxt      = CNT_LOAD;
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    led_nxt      = pat[{win, 2'b00} +: 4];
                    busy_nxt     = 1'b1;
                end else begin
                    gnt_nxt  = '0;
                    led_nxt  = IDLE_PAT;
                    busy_nxt = 1'b0;
                end
            end
            SHOW: begin
                if (slice_end) begin
                    ptr_nxt = base;
                    if (win_vld) begin
                        own_nxt      = win;
                        cnt_nxt      = CNT_LOAD;
                        gnt_nxt      = '0;
                        gnt_nxt[win] = 1'b1;
                        led_nxt      = pat[{win, 2'b00} +: 4];
                        busy_nxt     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        gnt_nxt   = '0;
                        led_nxt   = IDLE_PAT;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                led_nxt   = IDLE_PAT;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            led   <= IDLE_PAT;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            own   <= own_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            led   <= led_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter (N_REQ=4, DWELL_CYC=8, IDLE_PAT=0) with an
// expected-value queue checked one cycle after each driven step.
module tb_led_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] pat = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  led;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [3:0] l;
        logic       b;
    } exp_t;

    exp_t sb[$];

    led_arbiter #(
        .N_REQ(4),
        .DWELL_CYC(8),
        .IDLE_PAT(4'b0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .pat(pat),
        .gnt(gnt),
        .busy(busy),
        .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [3:0] g, input logic [3:0] l,
                        input logic b);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.l   = l;
        e.b   = b;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        n_run++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        assert ({gnt, led, busy} === {e.g, e.l, e.b})
        else begin
            n_fail++;
            $error("FAIL %s: got gnt=%b led=%b busy=%b, want gnt=%b led=%b busy=%b",
                   e.tag, gnt, led, busy, e.g, e.l, e.b);
        end
    endtask

    // Queue the expectation, let one clock edge pass, then check #1 after it.
    task automatic tick(input string tag, input logic [3:0] g, input logic [3:0] l,
                        input logic b);
        push(tag, g, l, b);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_now(input string tag, input logic [3:0] g, input logic [3:0] l,
                             input logic b);
        push(tag, g, l, b);
        compare_front();
    endtask

    initial begin
        logic [3:0] oh;

        // Reset state
        #1;
        check_now("reset_init", 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick("idle_no_req", 4'b0000, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of requester 1's slice
        req = 4'b0010;
        pat = 16'h0060;
        tick("r1_grant", 4'b0010, 4'b0110, 1'b1);
        tick("r1_hold1", 4'b0010, 4'b0110, 1'b1);
        tick("r1_hold2", 4'b0010, 4'b0110, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_now("async_reset", 4'b0000, 4'b0000, 1'b0);
        tick("reset_held", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        tick("post_reset_grant", 4'b0010, 4'b0110, 1'b1);
        req = 4'b0000;
        tick("r1_release", 4'b0000, 4'b0000, 1'b0);

        // Sole requester 2: continuous grant, pattern re-sampled at 8-cycle boundary
        req = 4'b0100;
        pat = 16'h0A00;
        tick("sole_grant", 4'b0100, 4'b1010, 1'b1);
        tick("sole_c1", 4'b0100, 4'b1010, 1'b1);
        tick("sole_c2", 4'b0100, 4'b1010, 1'b1);
        pat = 16'h0500;
        for (int c = 3; c < 8; c++)
            tick($sformatf("sole_old_pat_c%0d", c), 4'b0100, 4'b1010, 1'b1);
        tick("sole_boundary", 4'b0100, 4'b0101, 1'b1);
        for (int c = 1; c < 8; c++)
            tick($sformatf("sole_new_pat_c%0d", c), 4'b0100, 4'b0101, 1'b1);
        req = 4'b0000;
        tick("sole_release", 4'b0000, 4'b0000, 1'b0);

        // Wrap fairness: pointer sits at 3 after requester 2's slices
        req = 4'b1001;
        pat = 16'hC003;
        for (int c = 0; c < 8; c++)
            tick($sformatf("wrap_r3_c%0d", c), 4'b1000, 4'b1100, 1'b1);
        for (int c = 0; c < 8; c++)
            tick($sformatf("wrap_r0_c%0d", c), 4'b0001, 4'b0011, 1'b1);
        tick("wrap_back_r3", 4'b1000, 4'b1100, 1'b1);
        req = 4'b0000;
        tick("wrap_release", 4'b0000, 4'b0000, 1'b0);

        // Full rotation from pointer 0, each slot exactly 8 cycles with no gap
        req = 4'b1111;
        pat = 16'h8421;
        for (int c = 0; c < 40; c++) begin
            oh = 4'b0001 << ((c / 8) % 4);
            tick($sformatf("rot_c%0d", c), oh, oh, 1'b1);
        end

        // req[0] falls on its expiring edge while req[2] is pending
        req = 4'b0100;
        tick("simul_handover", 4'b0100, 4'b0100, 1'b1);
        req = 4'b0000;
        tick("simul_release", 4'b0000, 4'b0000, 1'b0);

        // Early release on the 3rd cycle of a grant
        req = 4'b0010;
        pat = 16'h8060;
        tick("early_grant", 4'b0010, 4'b0110, 1'b1);
        tick("early_c1", 4'b0010, 4'b0110, 1'b1);
        tick("early_c2", 4'b0010, 4'b0110, 1'b1);
        req = 4'b0000;
        tick("early_release", 4'b0000, 4'b0000, 1'b0);
        tick("early_idle", 4'b0000, 4'b0000, 1'b0);
        req = 4'b1000;
        tick("idle_regrant", 4'b1000, 4'b1000, 1'b1);
        req = 4'b0000;
        tick("final_release", 4'b0000, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Round-robin arbiter that shares the board's 4-bit LED bank among several internal requesters.
- Each requester raises a request with a 4-bit pattern; the arbiter grants one requester at a time for a bounded time slice and drives `led[3:0]` with that requester's latched pattern.
- Sits between status/debug sources in `top` and the `led[3:0]` output port.
- When no requester is granted, the bank shows a fixed idle pattern.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DWELL_CYC`, 8, maximum grant length in clock cycles (>=1)
- `IDLE_PAT`, 4'b0000, LED value when no grant is active
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request, level-sensitive
- `pat`  in  4*N_REQ  per-requester LED pattern; requester k uses `pat[4k+3:4k]`
- `gnt`  out  N_REQ  one-hot grant, registered; all-zero when idle
- `busy`  out  1  high while any grant is active
- `led`  out  4  registered LED drive

## Operation
- Reset (`reset`=0):
  - State machine state = IDLE.
  - `gnt`=0, `busy`=0, `led`=IDLE_PAT.
  - Round-robin pointer `ptr`=0; slice counter=0.
- States: IDLE, SHOW.
- Arbitration (combinational, evaluated at every decision edge):
  - Search `req` starting at `ptr`, then `ptr`+1, and so on, wrapping modulo N_REQ.
  - The first set bit wins.
- IDLE:
  - If `req`!=0: grant the winner k, set `gnt`=onehot(k), latch `led`=pat[k], load counter=DWELL_CYC-1, set `busy`=1, go to SHOW.
  - Otherwise hold the idle outputs.
- SHOW, owner k. The slice ends at an edge where either:
  - counter==0 (slice expired), or
  - `req[k]`==0 (early release).
- SHOW, slice not ending: counter decrements; `gnt`, `led` and `busy` hold.
- SHOW, slice ending:
  - Set `ptr`=(k+1) mod N_REQ first; arbitration uses the updated pointer.
  - If any `req` remains, grant the new winner at the same edge (no idle gap), re-latch its pattern and reload the counter.
  - If `req`==0: `gnt`=0, `busy`=0, `led`=IDLE_PAT, go to IDLE.
- Sole requester: a requester that keeps `req` high with no competitor is re-granted at slice end.
  - `gnt` stays high continuously.
  - Its pattern is re-sampled at each slice boundary.
- Pattern latching: `pat` is sampled only at grant edges. Changes to `pat` during a slice do not affect `led`.
- Counter width is clog2(DWELL_CYC), minimum 1 bit. With DWELL_CYC=1 every grant lasts exactly one cycle.

## Timing
- Request-to-grant latency: `req` high at edge n while in IDLE gives `gnt`/`led`/`busy` valid after edge n (1 cycle).
- Full slice: `gnt` high for exactly DWELL_CYC cycles per slice.
- Early release: `req[k]` sampled low at an edge ends the grant at that same edge. `gnt[k]` is therefore high for at most 1 cycle after `req[k]` falls.
- Handover: the old `gnt` falls and the new `gnt` rises on the same edge; `gnt` is never multi-hot.
- `led` always changes on the same edge as `gnt`.
- Reset mid-slice:
  - Outputs go to their reset values immediately (asynchronous).
  - On reset release, arbitration restarts from `ptr`=0 at the first edge.

## Test plan
- Reset: assert `reset`=0 while requester 1 is mid-slice -> `gnt`=0000, `busy`=0, `led`=0000 without waiting for a clock edge; after release with `req`=0010, `gnt`=0010 one cycle later.
- Single requester: `req`=0100 held, `pat[11:8]`=1010, DWELL_CYC=8 -> `gnt`=0100 continuous, `led`=1010. Change `pat[11:8]` to 0101 in mid-slice -> `led` updates only at the next 8-cycle boundary.
- Full rotation: `req`=1111 held, patterns 0001/0010/0100/1000 -> `gnt` sequence 0001, 0010, 0100, 1000, 0001, each exactly 8 cycles, no zero cycles between grants.
- Early release: `req`=0010 alone, drop `req[1]` on the 3rd cycle of grant -> `gnt`=0000, `led`=IDLE_PAT, `busy`=0 at that edge; state returns to IDLE.
- Wrap fairness: after a grant to requester 2 (`ptr`=3), assert `req`=1001 -> `gnt`=1000 first, then 0001.
- Simultaneous: with requester 0 owning, `req[0]` falls on the same edge as counter==0 while `req[2]` is high -> single handover to `gnt`=0100 at that edge; never two grants, never an idle cycle.
